// File: rtl/usb_pkt_writer.sv
// Assembles a USB data packet (PID, payload, optional CRC16) and writes it byte by byte
// through DPRAM port A. Define USB_CRC16_EN to compile in the CRC16 trailer.
module usb_pkt_writer #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_PAYLOAD = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            pid,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  zlp,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  enable_port_a,
    output logic                  write_port_a,
    output logic [ADDR_WIDTH-1:0] address_port_a,
    output logic [DATA_WIDTH-1:0] data_in_port_a,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] pkt_len,
    output logic [ADDR_WIDTH-1:0] pkt_base,
    output logic                  err_overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_PAYLOAD,
`ifdef USB_CRC16_EN
        S_CRC_LO,
        S_CRC_HI,
`endif
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LP_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_MAX = ADDR_WIDTH'(MAX_PAYLOAD);
`ifdef USB_CRC16_EN
    localparam logic [ADDR_WIDTH-1:0] LP_OVH = ADDR_WIDTH'(3);
`else
    localparam logic [ADDR_WIDTH-1:0] LP_OVH = ADDR_WIDTH'(1);
`endif

    state_t                r_state;
    logic [3:0]            r_pid;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_zlp;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_ovf;
    logic                  r_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_len;
    logic                  r_err;
`ifdef USB_CRC16_EN
    logic [15:0]           r_crc;
`endif

    logic                  w_ready;
    logic                  w_hs;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic                  w_at_max;

`ifdef USB_CRC16_EN
    // Reflected USB CRC16 (0xA001), one byte processed LSB first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction
`endif

    assign w_ready   = (r_state == S_PAYLOAD);
    assign w_hs      = in_valid & w_ready;
    assign w_cnt_nxt = r_cnt + LP_ONE;
    assign w_at_max  = (w_cnt_nxt == LP_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pid   <= '0;
            r_base  <= '0;
            r_zlp   <= 1'b0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_en    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_len   <= '0;
            r_err   <= 1'b0;
`ifdef USB_CRC16_EN
            r_crc   <= '1;
`endif
        end else begin
            r_en   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pid   <= pid;
                        r_base  <= base_addr;
                        r_zlp   <= zlp;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_len   <= '0;
                        r_err   <= 1'b0;
`ifdef USB_CRC16_EN
                        r_crc   <= '1;
`endif
                        r_state <= S_PID;
                    end
                end
                S_PID: begin
                    r_en   <= 1'b1;
                    r_addr <= r_base;
                    r_data <= {~r_pid, r_pid};
                    if (!r_zlp)
                        r_state <= S_PAYLOAD;
                    else
`ifdef USB_CRC16_EN
                        r_state <= S_CRC_LO;
`else
                        r_state <= S_DONE;
`endif
                end
                S_PAYLOAD: begin
                    if (w_hs) begin
                        r_en   <= 1'b1;
                        r_addr <= r_addr + LP_ONE;
                        r_data <= in_data;
                        r_cnt  <= w_cnt_nxt;
`ifdef USB_CRC16_EN
                        r_crc  <= crc16_upd(r_crc, in_data);
`endif
                        // Hitting the size limit without in_last truncates the payload.
                        if (in_last || w_at_max) begin
                            r_ovf   <= ~in_last;
`ifdef USB_CRC16_EN
                            r_state <= S_CRC_LO;
`else
                            r_state <= S_DONE;
`endif
                        end
                    end
                end
`ifdef USB_CRC16_EN
                S_CRC_LO: begin
                    r_en    <= 1'b1;
                    r_addr  <= r_addr + LP_ONE;
                    r_data  <= ~r_crc[7:0];
                    r_state <= S_CRC_HI;
                end
                S_CRC_HI: begin
                    r_en    <= 1'b1;
                    r_addr  <= r_addr + LP_ONE;
                    r_data  <= ~r_crc[15:8];
                    r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_len   <= r_cnt + LP_OVH;
                    r_err   <= r_ovf;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready       = w_ready;
    assign enable_port_a  = r_en;
    assign write_port_a   = r_en;
    assign address_port_a = r_addr;
    assign data_in_port_a = r_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pkt_len        = r_len;
    assign pkt_base       = r_base;
    assign err_overflow   = r_err;

endmodule
